alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream issue stage for the registered 12-bit ALU. Buffers tagged ALU commands
//  (a, b, sel) in a small FIFO and drives them one at a time onto the ALU operand inputs.
//  Captures the ALU result after its fixed 1-cycle latency and returns it, with the
//  command's tag, over a valid/ready response port.
// PARAMETERS
//  WIDTH  12  operand/result width; must match the ALU WIDTH
//  DEPTH  4   command FIFO entries; power of 2, >=2
//  TAG_W  4   width of the opaque tag carried from command to response
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, synchronous, active-high
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      FIFO can accept; = !full, combinational from count
//  cmd_a      in   WIDTH  operand a
//  cmd_b      in   WIDTH  operand b
//  cmd_sel    in   4      ALU function code (ADD=0 .. EQ=f)
//  cmd_tag    in   TAG_W  tag returned with the result
//  alu_a      out  WIDTH  to ALU a; registered
//  alu_b      out  WIDTH  to ALU b; registered
//  alu_sel    out  4      to ALU sel; registered
//  alu_out    in   WIDTH  from ALU out; valid 1 cycle after operands are presented
//  rsp_valid  out  1      result available
//  rsp_ready  in   1      consumer accepts
//  rsp_data   out  WIDTH  result
//  rsp_tag    out  TAG_W  tag of the command that produced rsp_data
//  rsp_err    out  1      divide-by-zero flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0 except cmd_ready=1. FIFO empty, FSM in IDLE. An in-flight
//    result is discarded; no response is ever produced for it.
//  - Push: on cmd_valid&&cmd_ready. No bypass: an entry pops no earlier than the edge
//    after its push. Push and pop in the same cycle are both honoured.
//  - FSM (one command in flight; throughput 1 per 3 cycles with rsp_ready held high):
//    IDLE:    FIFO non-empty -> pop; load alu_a/b/sel and the tag reg -> EXEC.
//    EXEC:    operands are stable at the ALU inputs; the ALU samples at the end edge -> CAP.
//    CAP:     rsp_data<=alu_out; rsp_tag<=tag reg; rsp_valid<=1 -> RESP.
//    RESP:    hold rsp_* stable while !rsp_ready.
//             On handshake: rsp_valid<=0. If FIFO non-empty, pop and load operands -> EXEC;
//             otherwise -> IDLE.
//  - alu_a/b/sel hold their last value outside EXEC. The ALU output is used only in CAP.
//  - Latency: command accepted at edge N into an empty, idle block -> rsp_valid high after edge N+3.
//  - Results pass through unmodified. GT/EQ results are 0/1 zero-extended. Width
//    truncation of ADD/SUB/MULT is the ALU's.
//  - FIFO full: cmd_ready=0; the command is held upstream.
//  - Pointer wrap: mod DEPTH, with count width clog2(DEPTH)+1.
// CONFIGURATION
//  DIVZERO_TRAP_EN defined: a command with sel==DIV and b==0 still issues. In CAP,
//    rsp_data<={WIDTH{1'b1}} and rsp_err=1 replace the ALU value. All other commands
//    give rsp_err=0.
//  Not defined: the ALU divide result passes through unchanged; rsp_err is tied to 0.
// STRUCTURE
//  - Package alu_pkg: ALU opcode localparams (ADD..EQ) and the FSM state encoding
//    (IDLE/EXEC/CAP/RESP). Shared with the ALU and its bench.
//  - One sub-module: alu_cmd_fifo, a synchronous FIFO of {tag,sel,b,a} with
//    push/pop/full/empty.
// TESTING
//  1. Reset, push ADD a=005 b=003 tag=1 at edge N, rsp_ready=1 -> rsp_valid after edge
//     N+3, rsp_data=008, rsp_tag=1, rsp_err=0.
//  2. Push DEPTH+1 commands back-to-back with rsp_ready=0 -> cmd_ready falls once the
//     FIFO is full. The first response holds stable and no command is lost after
//     rsp_ready=1.
//  3. Stream SUB 003-005, MULT 040*040, GT 800>001, RR 001 with rsp_ready=1 -> responses
//     in order: FFE, 000, 000, 800, one every 3 cycles.
//  4. DIV a=123 b=000 -> with DIVZERO_TRAP_EN: FFF and rsp_err=1. Without it: the ALU
//     value and rsp_err=0.
//  5. Assert rst during CAP with 2 commands queued -> after reset: no response, cmd_ready=1,
//     alu_* = 0. A new ADD 001+001 returns 002.
//  6. Toggle rsp_ready randomly for 200 random commands -> the response stream matches
//     the reference model in order and by tag.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the registered 12-bit ALU, its command
// sequencer and their benches.
//   - OP_*    : 4-bit ALU function codes (ADD=0 .. EQ=f)
//   - ST_*    : sequencer FSM state encoding (IDLE/EXEC/CAP/RESP)
package alu_pkg;

    localparam int SEL_W   = 4;
    localparam int STATE_W = 2;

    localparam logic [SEL_W-1:0] OP_ADD  = 4'h0;
    localparam logic [SEL_W-1:0] OP_SUB  = 4'h1;
    localparam logic [SEL_W-1:0] OP_MULT = 4'h2;
    localparam logic [SEL_W-1:0] OP_DIV  = 4'h3;
    localparam logic [SEL_W-1:0] OP_SHL  = 4'h4;
    localparam logic [SEL_W-1:0] OP_SHR  = 4'h5;
    localparam logic [SEL_W-1:0] OP_RL   = 4'h6;
    localparam logic [SEL_W-1:0] OP_RR   = 4'h7;
    localparam logic [SEL_W-1:0] OP_AND  = 4'h8;
    localparam logic [SEL_W-1:0] OP_OR   = 4'h9;
    localparam logic [SEL_W-1:0] OP_XOR  = 4'ha;
    localparam logic [SEL_W-1:0] OP_NOR  = 4'hb;
    localparam logic [SEL_W-1:0] OP_NAND = 4'hc;
    localparam logic [SEL_W-1:0] OP_XNOR = 4'hd;
    localparam logic [SEL_W-1:0] OP_GT   = 4'he;
    localparam logic [SEL_W-1:0] OP_EQ   = 4'hf;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_EXEC = 2'd1;
    localparam logic [STATE_W-1:0] ST_CAP  = 2'd2;
    localparam logic [STATE_W-1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding packed {tag, sel, b, a} commands.
// No bypass: an entry is visible on rd_data no earlier than the edge after
// its push. Simultaneous push and pop are both honoured.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, wr_data     write request / data (ignored when full)
//   pop,  rd_data     read request (ignored when empty) / head entry
//   full, empty       occupancy flags, decoded from the registered count
module alu_cmd_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issue stage for the registered (1-cycle latency) ALU.
// Buffers tagged commands, drives them one at a time onto the ALU operand
// registers, captures the result and returns it with its tag over a
// valid/ready response port. One command in flight; 3 cycles per command.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/ready, cmd_a/b/sel/tag command input (ready = FIFO not full)
//   alu_a/b/sel (out), alu_out (in)  registered ALU operands / ALU result
//   rsp_valid/ready, rsp_data/tag    response output
//   rsp_err                          divide-by-zero flag
// Optional build macro: DIVZERO_TRAP_EN -- DIV with b==0 returns all-ones
// and rsp_err=1 instead of the ALU value. Undefined: rsp_err stays 0.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_sel,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);
    localparam int DATA_W = TAG_W + SEL_W + 2 * WIDTH;

    logic [DATA_W-1:0]  fifo_rd_data;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [WIDTH-1:0]   f_a, f_b;
    logic [SEL_W-1:0]   f_sel;
    logic [TAG_W-1:0]   f_tag;

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic               rsp_err_q, rsp_err_d;
    logic               div_trap;

    alu_cmd_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid),
        .wr_data ({cmd_tag, cmd_sel, cmd_b, cmd_a}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign f_a   = fifo_rd_data[WIDTH-1:0];
    assign f_b   = fifo_rd_data[2*WIDTH-1:WIDTH];
    assign f_sel = fifo_rd_data[2*WIDTH+SEL_W-1:2*WIDTH];
    assign f_tag = fifo_rd_data[DATA_W-1:2*WIDTH+SEL_W];

    // Operand regs still hold the issued command during CAP.
`ifdef DIVZERO_TRAP_EN
    assign div_trap = (alu_sel_q == OP_DIV) && (alu_b_q == '0);
`else
    assign div_trap = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    alu_a_d   = f_a;
                    alu_b_d   = f_b;
                    alu_sel_d = f_sel;
                    tag_d     = f_tag;
                    state_d   = ST_EXEC;
                end
            end
            // ALU samples the stable operands at the end of this cycle.
            ST_EXEC: state_d = ST_CAP;
            ST_CAP: begin
                rsp_data_d  = div_trap ? {WIDTH{1'b1}} : alu_out;
                rsp_err_d   = div_trap;
                rsp_tag_d   = tag_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        alu_a_d   = f_a;
                        alu_b_d   = f_b;
                        alu_sel_d = f_sel;
                        tag_d     = f_tag;
                        state_d   = ST_EXEC;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a registered ALU model drives alu_out; a
// command-level reference queue predicts every response; a negedge monitor
// compares each handshake, hold stability and cmd_ready bounds.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 12;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
    logic [3:0]       cmd_sel = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out = '0;
    logic [3:0]       alu_sel;
    logic             rsp_valid, rsp_err;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [3:0] sel);
        case (sel)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MULT: return a * b;
            OP_DIV:  return (b == 0) ? '0 : a / b;
            OP_SHL:  return a << 1;
            OP_SHR:  return a >> 1;
            OP_RL:   return (a << 1) | (a >> (WIDTH - 1));
            OP_RR:   return (a >> 1) | (a << (WIDTH - 1));
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_NAND: return ~(a & b);
            OP_XNOR: return ~(a ^ b);
            OP_GT:   return ($signed(a) > $signed(b)) ? WIDTH'(1) : '0;
            default: return (a == b) ? WIDTH'(1) : '0;
        endcase
    endfunction

    // External registered ALU: one cycle from operands to alu_out.
    always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_sel);

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    function automatic rsp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [3:0] sel, input logic [TAG_W-1:0] tag);
        rsp_t r;
        r.data = alu_f(a, b, sel);
        r.tag  = tag;
        r.err  = 1'b0;
`ifdef DIVZERO_TRAP_EN
        if (sel == OP_DIV && b == 0) begin
            r.data = '1;
            r.err  = 1'b1;
        end
`endif
        return r;
    endfunction

    rsp_t             exp_q[$];
    logic [WIDTH-1:0] hs_data_q[$];
    logic [TAG_W-1:0] hs_tag_q[$];
    logic             hs_err_q[$];
    int               hs_cyc_q[$];
    int               n_chk = 0, n_pass = 0, cyc = 0;
    int               rdy_mode = 1;   // 0 low, 1 high, 2 random
    logic             hold_v = 1'b0;
    rsp_t             hold_r, mon_e;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: inputs and registered outputs are stable here until the next edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_hold_fields", {rsp_err, rsp_tag, rsp_data}, {hold_r.err, hold_r.tag, hold_r.data});
            end
            // At most one command sits outside the FIFO.
            if (exp_q.size() < DEPTH) chk("cmd_ready_open", 32'(cmd_ready), 32'd1);
            else if (exp_q.size() == DEPTH + 1) chk("cmd_ready_full", 32'(cmd_ready), 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_rsp: got data %0h tag %0h, required no response", rsp_data, rsp_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                    chk("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
                    chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                end
                hs_data_q.push_back(rsp_data);
                hs_tag_q.push_back(rsp_tag);
                hs_err_q.push_back(rsp_err);
                hs_cyc_q.push_back(cyc);
            end
            hold_v = rsp_valid && !rsp_ready;
            hold_r.data = rsp_data;
            hold_r.tag  = rsp_tag;
            hold_r.err  = rsp_err;
            if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_a, cmd_b, cmd_sel, cmd_tag));
        end
    end

    // Called just after a posedge; returns just after the edge that accepts it.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [3:0] sel, input logic [TAG_W-1:0] tag);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_tag = tag; cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!cmd_ready) begin
            n_chk++;
            $display("FAIL send_timeout: cmd_ready stuck 0, required 1 within 300 cycles");
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (hs_data_q.size() < n && k < 400) begin
            k++;
            @(negedge clk);
        end
        if (hs_data_q.size() < n) begin
            n_chk++;
            $display("FAIL wait_rsp_timeout: got %0d responses, required %0d", hs_data_q.size(), n);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((exp_q.size() != 0 || rsp_valid) && k < 2000) begin
            k++;
            @(negedge clk);
        end
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hs();
        hs_data_q.delete(); hs_tag_q.delete(); hs_err_q.delete(); hs_cyc_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_alu_ops", {alu_sel, alu_b, alu_a}, 32'd0);

        // 1. Latency: accepted at edge N -> valid after edge N+3
        @(posedge clk); #1;
        clear_hs();
        send(12'h005, 12'h003, OP_ADD, 4'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_latency_valid", 32'(rsp_valid), 32'(k == 3));
        end
        chk("t1_data", 32'(rsp_data), 32'h008);
        chk("t1_tag", 32'(rsp_tag), 32'd1);
        chk("t1_err", 32'(rsp_err), 32'd0);
        wait_drain();

        // 2. Fill with rsp_ready low, backpressure, then drain
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1 clear_hs();
        for (int i = 0; i <= DEPTH; i++) send(WIDTH'(16 + i), WIDTH'(i + 1), OP_ADD, TAG_W'(i));
        @(negedge clk);
        chk("t2_full_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        cmd_a = 12'h0aa; cmd_b = 12'h055; cmd_sel = OP_XOR; cmd_tag = 4'd5; cmd_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t2_blocked_ready", 32'(cmd_ready), 32'd0);
            chk("t2_hold_valid", 32'(rsp_valid), 32'd1);
        end
        rdy_mode = 1;
        @(posedge clk); #1;
        send(12'h0aa, 12'h055, OP_XOR, 4'd5);
        wait_drain();
        chk("t2_count", 32'(hs_data_q.size()), 32'(DEPTH + 2));
        for (int i = 0; i < hs_tag_q.size(); i++) chk("t2_tag_order", 32'(hs_tag_q[i]), 32'(i));
        if (hs_data_q.size() == DEPTH + 2) chk("t2_last_data", 32'(hs_data_q[DEPTH + 1]), 32'h0ff);

        // 3. Streamed ops: literal results, one per 3 cycles
        clear_hs();
        send(12'h003, 12'h005, OP_SUB, 4'd2);
        send(12'h040, 12'h040, OP_MULT, 4'd3);
        send(12'h800, 12'h001, OP_GT, 4'd4);
        send(12'h001, 12'h000, OP_RR, 4'd5);
        wait_rsp(4);
        if (hs_data_q.size() >= 4) begin
            chk("t3_sub", 32'(hs_data_q[0]), 32'hffe);
            chk("t3_mult", 32'(hs_data_q[1]), 32'h000);
            chk("t3_gt", 32'(hs_data_q[2]), 32'h000);
            chk("t3_rr", 32'(hs_data_q[3]), 32'h800);
            chk("t3_tag_last", 32'(hs_tag_q[3]), 32'd5);
            for (int i = 1; i < 4; i++) chk("t3_spacing", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 32'd3);
        end
        wait_drain();

        // 4. Divide by zero
        clear_hs();
        send(12'h123, 12'h000, OP_DIV, 4'd6);
        wait_rsp(1);
        if (hs_data_q.size() >= 1) begin
`ifdef DIVZERO_TRAP_EN
            chk("t4_div0_data", 32'(hs_data_q[0]), 32'hfff);
            chk("t4_div0_err", 32'(hs_err_q[0]), 32'd1);
`else
            chk("t4_div0_data", 32'(hs_data_q[0]), 32'h000);
            chk("t4_div0_err", 32'(hs_err_q[0]), 32'd0);
`endif
        end
        wait_drain();

        // 5. Reset during CAP with two commands queued
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1 clear_hs();
        send(12'h011, 12'h001, OP_ADD, 4'd8);
        send(12'h022, 12'h002, OP_ADD, 4'd9);
        send(12'h033, 12'h003, OP_ADD, 4'd10);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 1;
        @(negedge clk);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t5_alu_ops", {alu_sel, alu_b, alu_a}, 32'd0);
        repeat (8) begin
            @(negedge clk);
            chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(12'h001, 12'h001, OP_ADD, 4'd7);
        wait_rsp(1);
        if (hs_data_q.size() >= 1) chk("t5_add_after_rst", 32'(hs_data_q[0]), 32'h002);
        wait_drain();

        // 6. Random commands with random rsp_ready
        rdy_mode = 2;
        clear_hs();
        for (int i = 0; i < 200; i++) begin
            logic [WIDTH-1:0] ra, rb;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
            send(ra, rb, 4'($urandom_range(0, 15)), TAG_W'(i));
        end
        rdy_mode = 1;
        wait_drain();
        chk("t6_count", 32'(hs_data_q.size()), 32'd200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
